// File: rtl/mem_bus_ctrl.sv
// Load/store bus controller: address decode, wait-state read handshake,
// posted writes, and a bank of PC-match breakpoint channels.
module mem_bus_ctrl #(
    parameter int unsigned NUM_BP   = 4,
    parameter int unsigned RAM_WAIT = 1,
    parameter int unsigned DATA_W   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       addrIn,
    input  logic [DATA_W-1:0] write,
    input  logic              we,
    input  logic              re,
    output logic [DATA_W-1:0] read,
    output logic              ready,
    output logic [15:0]       memAddr,
    input  logic [DATA_W-1:0] romData,
    input  logic [DATA_W-1:0] stackData,
    input  logic [DATA_W-1:0] heapData,
    output logic              stackWe,
    output logic              heapWe,
    input  logic [3:0]        switch,
    output logic [15:0]       page,
    input  logic [31:0]       pcIn,
    output logic [NUM_BP-1:0] bpEn,
    output logic              bpHit,
    output logic [2:0]        bpHitIdx,
    output logic [31:0]       bpAddr
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;
    typedef enum logic [1:0] {RG_ROM, RG_HEAP, RG_STACK, RG_REG} region_t;

    localparam logic [31:0] BP_BASE   = 32'hFFFF_F000;
    localparam logic [31:0] BPA_LO    = BP_BASE + 32'(3 * NUM_BP);
    localparam logic [31:0] BPA_HI    = BPA_LO + 32'd1;
    localparam logic [31:0] SW_ADDR   = 32'hFFFF_0002;
    localparam logic [31:0] PAGE_ADDR = 32'hFFFF_1000;

    state_t              r_state, w_next;
    region_t             w_region, r_region;
    logic [31:0]         r_addr;
    logic [1:0]          r_cnt;
    logic [DATA_W-1:0]   r_read, r_page;
    logic [NUM_BP-1:0]   r_bpEn;
    logic [31:0]         r_bpReg [NUM_BP];
    logic                r_bpHit;
    logic [2:0]          r_bpHitIdx;
    logic [31:0]         r_bpAddr;
    logic                w_start, w_capture, w_hit;
    logic [2:0]          w_hitIdx;
    logic [DATA_W-1:0]   w_rdata;

    always_comb begin
        if (addrIn[31:20] == 12'h000)
            w_region = RG_ROM;
        else if (addrIn >= 32'h1000_0000 && addrIn <= 32'h8FFF_FFFF)
            w_region = RG_HEAP;
        else if (addrIn[31:16] == 16'hD000)
            w_region = RG_STACK;
        else
            w_region = RG_REG;
    end

    assign stackWe = we && (w_region == RG_STACK);
    assign heapWe  = we && (w_region == RG_HEAP);
    assign w_start = (r_state == S_IDLE) && re && !we;
    // Macros see the live address for posted writes and read launch, then the latched one
    assign memAddr = (r_state == S_IDLE) ? addrIn[15:0] : r_addr[15:0];
    assign ready   = (r_state != S_WAIT);
    assign read    = r_read;
    assign page    = r_page;
    assign bpEn    = r_bpEn;
    assign bpHit   = r_bpHit;
    assign bpHitIdx = r_bpHitIdx;
    assign bpAddr  = r_bpAddr;

    always_comb begin
        w_next    = r_state;
        w_capture = 1'b0;
        case (r_state)
            S_IDLE: if (w_start) w_next = S_WAIT;
            S_WAIT: if (r_cnt == 2'd0) begin
                w_capture = 1'b1;
                w_next    = S_DONE;
            end
            S_DONE: w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_rdata = '0;
        case (r_region)
            RG_ROM:   w_rdata = romData;
            RG_HEAP:  w_rdata = heapData;
            RG_STACK: w_rdata = stackData;
            default: begin
                if (r_addr == SW_ADDR)   w_rdata = {{(DATA_W-4){1'b0}}, switch};
                if (r_addr == PAGE_ADDR) w_rdata = r_page;
                if (r_addr == BPA_LO)    w_rdata = r_bpAddr[15:0];
                if (r_addr == BPA_HI)    w_rdata = r_bpAddr[31:16];
                for (int unsigned i = 0; i < NUM_BP; i++) begin
                    if (r_addr == BP_BASE + 32'(3 * i))
                        w_rdata = {{(DATA_W-1){1'b0}}, r_bpEn[i]};
                    if (r_addr == BP_BASE + 32'(3 * i + 1))
                        w_rdata = r_bpReg[i][15:0];
                    if (r_addr == BP_BASE + 32'(3 * i + 2))
                        w_rdata = r_bpReg[i][31:16];
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_addr   <= '0;
            r_region <= RG_REG;
            r_read   <= '0;
        end else begin
            r_state <= w_next;
            if (w_start) begin
                r_addr   <= addrIn;
                r_region <= w_region;
                r_cnt    <= (w_region == RG_REG) ? 2'd0 : 2'(RAM_WAIT - 1);
            end else if (r_state == S_WAIT && r_cnt != 2'd0) begin
                r_cnt <= r_cnt - 2'd1;
            end
            if (w_capture)
                r_read <= w_rdata;
        end
    end

    // Lowest enabled channel whose address equals the current PC
    always_comb begin
        w_hit    = 1'b0;
        w_hitIdx = '0;
        for (int unsigned i = 0; i < NUM_BP; i++) begin
            if (!w_hit && r_bpEn[i] && pcIn == r_bpReg[i]) begin
                w_hit    = 1'b1;
                w_hitIdx = 3'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_page     <= '0;
            r_bpEn     <= '0;
            r_bpHit    <= 1'b0;
            r_bpHitIdx <= '0;
            r_bpAddr   <= '0;
            for (int unsigned i = 0; i < NUM_BP; i++)
                r_bpReg[i] <= '0;
        end else begin
            r_bpHit    <= w_hit;
            r_bpHitIdx <= w_hitIdx;
            if (w_hit)
                r_bpAddr <= pcIn;
            // Later assignments win, so a software write overrides the capture per half
            if (we) begin
                if (addrIn == PAGE_ADDR) r_page <= write;
                if (addrIn == BPA_LO)    r_bpAddr[15:0]  <= write;
                if (addrIn == BPA_HI)    r_bpAddr[31:16] <= write;
                for (int unsigned i = 0; i < NUM_BP; i++) begin
                    if (addrIn == BP_BASE + 32'(3 * i))     r_bpEn[i] <= |write;
                    if (addrIn == BP_BASE + 32'(3 * i + 1)) r_bpReg[i][15:0]  <= write;
                    if (addrIn == BP_BASE + 32'(3 * i + 2)) r_bpReg[i][31:16] <= write;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Directed bench for mem_bus_ctrl with NUM_BP=4, RAM_WAIT=2 and
// two-cycle synchronous macro models behind the bus.
module tb_mem_bus_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] addrIn;
    logic [15:0] write;
    logic        we, re;
    logic [15:0] read;
    logic        ready;
    logic [15:0] memAddr;
    logic [15:0] romData, stackData, heapData;
    logic        stackWe, heapWe;
    logic [3:0]  switch;
    logic [15:0] page;
    logic [31:0] pcIn;
    logic [3:0]  bpEn;
    logic        bpHit;
    logic [2:0]  bpHitIdx;
    logic [31:0] bpAddr;

    int errors = 0;
    int checks = 0;

    mem_bus_ctrl #(.NUM_BP(4), .RAM_WAIT(2), .DATA_W(16)) dut (
        .clk(clk), .rst(rst), .addrIn(addrIn), .write(write), .we(we), .re(re),
        .read(read), .ready(ready), .memAddr(memAddr), .romData(romData),
        .stackData(stackData), .heapData(heapData), .stackWe(stackWe),
        .heapWe(heapWe), .switch(switch), .page(page), .pcIn(pcIn),
        .bpEn(bpEn), .bpHit(bpHit), .bpHitIdx(bpHitIdx), .bpAddr(bpAddr)
    );

    always #5 clk = ~clk;

    // Two-stage synchronous macro models
    logic [15:0] stack_mem [64];
    logic [15:0] heap_mem [64];
    logic [15:0] stack_p1, heap_p1, rom_p1;
    always @(posedge clk) begin
        if (stackWe) stack_mem[memAddr[5:0]] <= write;
        if (heapWe)  heap_mem[memAddr[5:0]]  <= write;
        stack_p1  <= stack_mem[memAddr[5:0]];
        heap_p1   <= heap_mem[memAddr[5:0]];
        rom_p1    <= memAddr ^ 16'h5A5A;
        stackData <= stack_p1;
        heapData  <= heap_p1;
        romData   <= rom_p1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [31:0] a, input logic [15:0] d);
        addrIn = a; write = d; we = 1'b1; re = 1'b0;
        tick();
        we = 1'b0;
    endtask

    // Returns the number of ready-low cycles and the data seen at DONE
    task automatic do_read(input logic [31:0] a, output int low, output logic [15:0] d);
        addrIn = a; re = 1'b1; we = 1'b0;
        low = 0;
        tick();
        while (ready === 1'b0 && low < 20) begin
            low++;
            tick();
        end
        if (low >= 20) low = 99;
        d = read;
        re = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1; we = 1'b0; re = 1'b0; addrIn = '0; write = '0;
        switch = 4'h0; pcIn = 32'hFFFF_FFFF;
        tick(); tick();
        rst = 1'b0;
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", ready); end
        checks++; if (read !== 16'h0) begin errors++; $display("FAIL reset_read: got %h want 0000", read); end
        checks++; if (page !== 16'h0) begin errors++; $display("FAIL reset_page: got %h want 0000", page); end
        checks++; if ({bpEn, bpHit, bpHitIdx} !== 8'h0) begin errors++; $display("FAIL reset_bp: got %b %b %h want 0", bpEn, bpHit, bpHitIdx); end
        checks++; if (bpAddr !== 32'h0) begin errors++; $display("FAIL reset_bpaddr: got %h want 0", bpAddr); end
    endtask

    task automatic test_regions();
        logic [31:0] addrs [5];
        logic [1:0]  exp   [5];
        addrs = '{32'h8FFF_FFFF, 32'h9000_0000, 32'hD000_FFFF, 32'hD001_0000, 32'h0FFF_FFFF};
        exp   = '{2'b01, 2'b00, 2'b10, 2'b00, 2'b00};
        we = 1'b1;
        for (int i = 0; i < 5; i++) begin
            addrIn = addrs[i];
            #1;
            checks++;
            if ({stackWe, heapWe} !== exp[i]) begin
                errors++;
                $display("FAIL region_we %h: got stack=%b heap=%b want %b", addrs[i], stackWe, heapWe, exp[i]);
            end
        end
        we = 1'b0;
        tick();
    endtask

    task automatic test_stack_read();
        int low; logic [15:0] d;
        addrIn = 32'hD000_0010; write = 16'hBEEF; we = 1'b1; re = 1'b0;
        #1;
        checks++; if (stackWe !== 1'b1 || memAddr !== 16'h0010) begin errors++; $display("FAIL stack_write: got we=%b addr=%h want 1 0010", stackWe, memAddr); end
        tick();
        we = 1'b0;
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL write_posted: got ready=%b want 1", ready); end
        do_read(32'hD000_0010, low, d);
        checks++; if (low !== 2) begin errors++; $display("FAIL stack_latency: got %0d want 2", low); end
        checks++; if (d !== 16'hBEEF) begin errors++; $display("FAIL stack_read: got %h want beef", d); end
        do_read(32'h0000_0123, low, d);
        checks++; if (low !== 2 || d !== 16'h5B79) begin errors++; $display("FAIL rom_read: got %0d %h want 2 5b79", low, d); end
    endtask

    task automatic test_reg_read();
        int low; logic [15:0] d;
        switch = 4'hA;
        do_read(32'hFFFF_0002, low, d);
        checks++; if (low !== 1) begin errors++; $display("FAIL reg_latency: got %0d want 1", low); end
        checks++; if (d !== 16'h000A) begin errors++; $display("FAIL switch_read: got %h want 000a", d); end
        do_read(32'hC000_0000, low, d);
        checks++; if (low !== 1 || d !== 16'h0000) begin errors++; $display("FAIL unmapped_read: got %0d %h want 1 0000", low, d); end
    endtask

    task automatic test_bp_hit();
        int low; logic [15:0] d;
        do_write(32'hFFFF_F007, 16'h0100);
        do_write(32'hFFFF_F008, 16'h0000);
        do_write(32'hFFFF_F006, 16'h0001);
        pcIn = 32'h0000_0100;
        tick();
        checks++; if (bpHit !== 1'b1 || bpHitIdx !== 3'd2) begin errors++; $display("FAIL bp_hit: got %b idx %0d want 1 idx 2", bpHit, bpHitIdx); end
        checks++; if (bpAddr !== 32'h0000_0100) begin errors++; $display("FAIL bp_capture: got %h want 00000100", bpAddr); end
        pcIn = 32'h0000_0300;
        tick();
        checks++; if (bpHit !== 1'b0 || bpEn !== 4'b0100) begin errors++; $display("FAIL bp_nohit: got hit=%b en=%b want 0 0100", bpHit, bpEn); end
        do_read(32'hFFFF_F006, low, d);
        checks++; if (d !== 16'h0001) begin errors++; $display("FAIL bp_en_readback: got %h want 0001", d); end
        do_read(32'hFFFF_F007, low, d);
        checks++; if (d !== 16'h0100) begin errors++; $display("FAIL bp_lo_readback: got %h want 0100", d); end
        do_read(32'hFFFF_F00C, low, d);
        checks++; if (d !== 16'h0100) begin errors++; $display("FAIL bpaddr_readback: got %h want 0100", d); end
    endtask

    task automatic test_bp_priority();
        do_write(32'hFFFF_F004, 16'h0200);
        do_write(32'hFFFF_F005, 16'h0000);
        do_write(32'hFFFF_F003, 16'h8000);
        do_write(32'hFFFF_F00A, 16'h0200);
        do_write(32'hFFFF_F00B, 16'h0000);
        do_write(32'hFFFF_F009, 16'h0001);
        pcIn = 32'h0000_0200;
        addrIn = 32'hFFFF_F00C; write = 16'h1234; we = 1'b1;
        tick();
        we = 1'b0;
        checks++; if (bpHit !== 1'b1 || bpHitIdx !== 3'd1) begin errors++; $display("FAIL bp_lowest: got %b idx %0d want 1 idx 1", bpHit, bpHitIdx); end
        checks++; if (bpAddr !== 32'h0000_1234) begin errors++; $display("FAIL bp_sw_override: got %h want 00001234", bpAddr); end
        do_write(32'hFFFF_F004, 16'h0999);
        checks++; if (bpHit !== 1'b1 || bpHitIdx !== 3'd1) begin errors++; $display("FAIL bp_prewrite: got %b idx %0d want 1 idx 1", bpHit, bpHitIdx); end
        tick();
        checks++; if (bpHit !== 1'b1 || bpHitIdx !== 3'd3) begin errors++; $display("FAIL bp_postwrite: got %b idx %0d want 1 idx 3", bpHit, bpHitIdx); end
        pcIn = 32'h0000_0300;
        tick();
    endtask

    task automatic test_we_re();
        addrIn = 32'hFFFF_1000; write = 16'h0055; we = 1'b1; re = 1'b1;
        #1;
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL wr_ready_before: got %b want 1", ready); end
        tick();
        checks++; if (ready !== 1'b1 || page !== 16'h0055) begin errors++; $display("FAIL wr_priority: got ready=%b page=%h want 1 0055", ready, page); end
        we = 1'b0; re = 1'b0;
        tick();
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL wr_no_fsm: got %b want 1", ready); end
    endtask

    task automatic test_back_to_back();
        logic [3:0] seq;
        switch = 4'h5;
        addrIn = 32'hFFFF_0002; re = 1'b1; we = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            seq[i] = ready;
            if (i == 1) begin
                checks++; if (read !== 16'h0005) begin errors++; $display("FAIL b2b_data: got %h want 0005", read); end
            end
        end
        re = 1'b0;
        checks++; if (seq !== 4'b0110) begin errors++; $display("FAIL b2b_ready_seq: got %b want 0110", seq); end
        tick(); tick();
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL b2b_idle: got %b want 1", ready); end
    endtask

    task automatic test_reset_mid_read();
        int low; logic [15:0] d;
        do_write(32'h1000_0004, 16'h7777);
        addrIn = 32'h1000_0004; re = 1'b1;
        tick();
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL heap_wait: got %b want 0", ready); end
        rst = 1'b1; re = 1'b0;
        tick();
        rst = 1'b0;
        checks++; if (ready !== 1'b1 || read !== 16'h0) begin errors++; $display("FAIL rst_mid_read: got ready=%b read=%h want 1 0000", ready, read); end
        checks++; if (page !== 16'h0 || bpEn !== 4'h0 || bpAddr !== 32'h0) begin errors++; $display("FAIL rst_regs: got page=%h en=%b bpaddr=%h want 0", page, bpEn, bpAddr); end
        do_read(32'hFFFF_F00A, low, d);
        checks++; if (d !== 16'h0000) begin errors++; $display("FAIL rst_bpreg: got %h want 0000", d); end
        do_read(32'h1000_0004, low, d);
        checks++; if (low !== 2 || d !== 16'h7777) begin errors++; $display("FAIL heap_after_rst: got %0d %h want 2 7777", low, d); end
    endtask

    initial begin
        test_reset();
        test_regions();
        test_stack_read();
        test_reg_read();
        test_bp_hit();
        test_bp_priority();
        test_we_re();
        test_back_to_back();
        test_reset_mid_read();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
